fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VEC_ADDR, default 32'h0000_0000: instruction-memory address of the reset vector; low half at this address, high half at +1.
REQ-002 Parameter INT_VEC_ADDR, default 32'h0000_0002: address of the interrupt vector; low half at this address, high half at +1.
REQ-003 i_clk  in  1  system clock; all state changes on the rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_stall  in  1  hazard stall from decode; hold the PC.
REQ-006 i_branch_taken  in  1  branch/jump resolved taken this cycle.
REQ-007 i_branch_target  in  32  new PC when i_branch_taken=1.
REQ-008 i_interrupt  in  1  external interrupt request, level or pulse; latched internally.
REQ-009 i_rti  in  1  one-cycle pulse: return-from-interrupt retired; unmasks interrupts.
REQ-010 i_imem_data  in  16  instruction-memory read word for address o_pc, valid combinationally in the same cycle.
REQ-011 o_pc  out  32  current fetch address driven to instruction memory.
REQ-012 o_fetch_valid  out  1  word at o_pc is a real instruction for decode.
REQ-013 o_save_pc  out  32  return PC to be pushed by the pipeline on interrupt entry.
REQ-014 o_save_valid  out  1  one-cycle strobe qualifying o_save_pc.
REQ-015 o_int_active  out  1  interrupt service in progress (interrupts masked).

Function
REQ-016 The FSM SHALL have states BOOT_LO, BOOT_HI, RUN, INT_LO and INT_HI.
REQ-017 BOOT_LO: o_pc=RESET_VEC_ADDR, o_fetch_valid=0; capture i_imem_data as the low half; go to BOOT_HI.
REQ-018 BOOT_HI: o_pc=RESET_VEC_ADDR+1, o_fetch_valid=0; PC <= {i_imem_data, low half}; go to RUN.
REQ-019 RUN: o_fetch_valid=1; next PC priority: i_branch_taken -> i_branch_target; else i_stall -> hold; else PC+1 (32-bit, wraps 32'hFFFF_FFFF -> 0).
REQ-020 Branch SHALL override stall when both are asserted in the same cycle.
REQ-021 A pending flag SHALL set on any cycle with i_interrupt=1 and stay set until the interrupt is taken; requests arriving while pending is already set merge.
REQ-022 The interrupt is taken in a RUN cycle with pending=1, o_int_active=0 and i_stall=0; that cycle: o_save_valid=1, o_save_pc=next PC per REQ-019 (branch target if taken), pending cleared, o_int_active set, go to INT_LO.
REQ-023 While i_stall=1, interrupt entry SHALL be deferred; pending is held.
REQ-024 INT_LO/INT_HI behave as BOOT_LO/BOOT_HI using INT_VEC_ADDR, o_fetch_valid=0, then RUN at the loaded vector.
REQ-025 i_branch_taken and i_stall SHALL be ignored in BOOT_*/INT_* states.
REQ-026 i_rti SHALL clear o_int_active on the next edge; if i_rti coincides with a take condition, the take is evaluated against the pre-edge o_int_active (not taken that cycle).
REQ-027 Interrupts raised while o_int_active=1 SHALL remain pending and be taken in the first eligible RUN cycle after unmask.
REQ-028 o_save_valid SHALL be 0 in every cycle other than the take cycle.

Reset
REQ-029 Assertion SHALL asynchronously force: state BOOT_LO, PC=RESET_VEC_ADDR, low-half register 0, pending=0, o_int_active=0, o_save_valid=0, o_save_pc=0, o_fetch_valid=0.
REQ-030 Reset asserted mid-vector-load or mid-service SHALL abandon it with no save strobe; the boot sequence restarts after deassertion.

Structure
REQ-031 State encoding (BOOT_LO..INT_HI) and default vector addresses SHALL live in the shared CPU package.
REQ-032 The PC register SHALL reuse the existing program_counter sub-module (enable = not holding); FSM and pending logic SHALL be in this module.

Verification
REQ-033 Reset release, mem[0]=16'h0040, mem[1]=16'h0000 -> o_pc 0, 1, then 32'h40 with o_fetch_valid=1 on the third cycle.
REQ-034 RUN at PC 32'h45, i_stall=1 for 2 cycles with i_branch_taken=1, target 32'h80, in the 2nd -> PC 45, 45, 80.
REQ-035 PC 32'h50, 1-cycle i_interrupt pulse, mem[2]=16'h0100, mem[3]=0 -> o_save_valid=1 with o_save_pc=32'h51, then o_pc 2, 3, 32'h100; o_int_active=1.
REQ-036 Interrupt during o_int_active=1 -> no entry; i_rti pulse -> entry on the first RUN cycle after unmask.
REQ-037 Interrupt and branch to 32'h90 in the same unstalled cycle -> o_save_pc=32'h90.
REQ-038 Reset asserted in INT_HI -> outputs at reset values immediately; after release, boot from RESET_VEC_ADDR, pending=0.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared CPU definitions for the fetch stage: FSM state encoding and default vector addresses.
package fetch_controller_pkg;

  typedef enum logic [2:0] {
    BOOT_LO = 3'd0,
    BOOT_HI = 3'd1,
    RUN     = 3'd2,
    INT_LO  = 3'd3,
    INT_HI  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_INT_VEC   = 32'h0000_0002;

  // Vectors are stored as two 16-bit words, low half first.
  function automatic logic [31:0] joinHalves(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fetch_controller_pc.sv
// Program counter register: loads i_d on enable, resets asynchronously to RESET_VAL.
module program_counter #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: boot vector load, sequential/branch fetch and interrupt entry.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VEC_ADDR = DEFAULT_RESET_VEC,
  parameter logic [31:0] INT_VEC_ADDR   = DEFAULT_INT_VEC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_interrupt,
  input  logic        i_rti,
  input  logic [15:0] i_imem_data,
  output logic [31:0] o_pc,
  output logic        o_fetch_valid,
  output logic [31:0] o_save_pc,
  output logic        o_save_valid,
  output logic        o_int_active
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  logic [15:0]  r_lowHalf;
  logic         r_pending;
  logic         r_intActive;
  logic [31:0]  w_pc;
  logic [31:0]  w_pcD;
  logic         w_pcEn;
  logic [31:0]  w_runNext;
  logic         w_take;
  logic         w_captureLow;

  program_counter #(.RESET_VAL(RESET_VEC_ADDR)) u_pc (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (w_pcEn),
    .i_d    (w_pcD),
    .o_q    (w_pc)
  );

  // Branch wins over stall; the take decision uses the pre-edge mask.
  assign w_runNext = i_branch_taken ? i_branch_target : (i_stall ? w_pc : w_pc + 32'd1);
  assign w_take    = (r_state == RUN) && r_pending && !r_intActive && !i_stall;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= BOOT_LO;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT_LO: w_nextState = BOOT_HI;
      BOOT_HI: w_nextState = RUN;
      RUN:     w_nextState = w_take ? INT_LO : RUN;
      INT_LO:  w_nextState = INT_HI;
      INT_HI:  w_nextState = RUN;
      default: w_nextState = BOOT_LO;
    endcase
  end

  always_comb begin
    o_pc          = w_pc;
    o_fetch_valid = 1'b0;
    o_save_valid  = 1'b0;
    o_save_pc     = 32'd0;
    w_pcEn        = 1'b0;
    w_pcD         = w_pc;
    w_captureLow  = 1'b0;
    case (r_state)
      BOOT_LO: begin
        o_pc         = RESET_VEC_ADDR;
        w_captureLow = 1'b1;
      end
      BOOT_HI: begin
        o_pc   = RESET_VEC_ADDR + 32'd1;
        w_pcEn = 1'b1;
        w_pcD  = joinHalves(i_imem_data, r_lowHalf);
      end
      RUN: begin
        o_fetch_valid = 1'b1;
        w_pcEn        = i_branch_taken || !i_stall;
        w_pcD         = w_runNext;
        o_save_valid  = w_take;
        o_save_pc     = w_take ? w_runNext : 32'd0;
      end
      INT_LO: begin
        o_pc         = INT_VEC_ADDR;
        w_captureLow = 1'b1;
      end
      INT_HI: begin
        o_pc   = INT_VEC_ADDR + 32'd1;
        w_pcEn = 1'b1;
        w_pcD  = joinHalves(i_imem_data, r_lowHalf);
      end
      default: begin
        o_pc = RESET_VEC_ADDR;
      end
    endcase
  end

  // A request arriving in the take cycle is folded into the interrupt being taken.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lowHalf   <= 16'd0;
      r_pending   <= 1'b0;
      r_intActive <= 1'b0;
    end else begin
      if (w_captureLow) begin
        r_lowHalf <= i_imem_data;
      end
      if (w_take) begin
        r_pending <= 1'b0;
      end else if (i_interrupt) begin
        r_pending <= 1'b1;
      end
      if (w_take) begin
        r_intActive <= 1'b1;
      end else if (i_rti) begin
        r_intActive <= 1'b0;
      end
    end
  end

  assign o_int_active = r_intActive;

endmodule
